cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
Top-level control-state sequencer for the mcpu core, directly upstream of the RAM operand reader. It owns the program counter and the instruction register, and drives the 4-bit control state `cs` that the reader decodes. It also drives the `addr` value the reader loads in the fetch and address-reload states. It advances through the read phases using the reader's `kp` (keep-reading) flag and its `adq` (next byte address).

Parameters:
RESET_PC, 16'h0000, program counter value loaded on reset
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  leave IDLE (level-sampled)
halt  in  1  from decoder; sampled in EXEC, stop after current instruction
mem_rd  in  1  from decoder; instruction needs an execute-time memory read
kp  in  1  reader keep-reading flag
adq  in  16  reader byte address (next unread byte)
opnd  in  64  reader assembled operand q
d  in  8  RAM read data (asynchronous-read RAM)
cs  out  4  control state
ir  out  8  instruction register, feeds reader opc
addr  out  16  address presented to reader
pc  out  16  program counter
retired  out  CNT_W  instructions completed, wraps

Behaviour:
- State codes are the shared state header values: IDLE=0, OPCFT=1, OPLFT=2, OPLRD=3, ADRD=4, EXERD=5, EXEC=6, HALT=7. `cs` is the registered state itself.
- Reset (async) values: cs=IDLE, pc=RESET_PC, ir=8'h00, retired=0, internal next-pc register=RESET_PC.
- addr is combinational:
  - pc in IDLE and OPCFT.
  - opnd[15:0] in ADRD.
  - 16'h0000 otherwise.
- IDLE: go to OPCFT on a clock edge where start=1; otherwise hold.
- OPCFT (1 cycle): ir<=d, where d is the byte at pc. Go to OPLFT.
- OPLFT (1 cycle): the reader decodes ir and sets kp. Go to OPLRD unconditionally.
- OPLRD: the reader consumes one byte per cycle.
  - Stay while kp=1 at the edge.
  - On the edge where kp=0, capture npc<=adq+1. This accounts for the byte the reader consumes on that same edge.
  - Exit to ADRD if mem_rd=1, else to EXEC.
  - Minimum dwell is 1 cycle. Byte counts that result: kp set with tim=6 gives 8 cycles; tim=2 gives 4 cycles; kp=0 at entry gives 1 cycle.
- ADRD (1 cycle): the reader reloads its address from addr. Go to EXERD.
- EXERD: same kp rule as OPLRD (stay while kp=1, exit on kp=0), then go to EXEC. npc is not updated here.
- EXEC (1 cycle):
  - pc<=npc.
  - retired<=retired+1, mod 2^CNT_W.
  - If halt=1 go to HALT, else go to OPCFT.
- HALT: hold indefinitely. Only rst leaves HALT; start is ignored.
- Address arithmetic is 16-bit and wraps: adq=16'hFFFF gives npc=16'h0000.
- Unknown or illegal state code: next state IDLE, pc unchanged.
- Reset asserted mid-instruction: immediate return to reset values. The partial operand is discarded and retired is not incremented.
- Inputs mem_rd and halt are sampled only in their stated states; they are don't-care elsewhere.

Optional Feature:
SINGLE_STEP_EN
- Defined: EXEC with halt=0 goes to IDLE instead of OPCFT. Each instruction then requires a new start. start must be sampled low for at least one edge in IDLE before it is honoured again, so a held start runs exactly one instruction.
- Undefined: free-running as above; start is only used to leave IDLE after reset.

Test Plan:
1. Reset with RESET_PC=16'h0010, start=1 one cycle -> cs sequence IDLE,OPCFT,OPLFT,OPLRD; addr=16'h0010 during OPCFT; ir=d value (e.g. 8'h3A) from OPLFT onward.
2. 8-byte operand: kp=1 for 7 OPLRD edges then 0, adq=16'h0011 at OPLRD entry, mem_rd=0 -> 8 OPLRD cycles, then EXEC; pc=16'h0019 after EXEC; retired=1.
3. 1-byte operand with mem_rd=1, opnd[15:0]=16'h4000 -> OPLRD 1 cycle, ADRD with addr=16'h4000, EXERD 1 cycle (kp=0), EXEC; pc=16'h0012.
4. halt=1 in EXEC -> cs=HALT and holds for 20 cycles with start toggling; pc and retired frozen.
5. rst pulsed asynchronously mid-OPLRD (between clock edges) -> cs=IDLE, pc=RESET_PC, retired=0 immediately, before the next edge.
6. Wrap: adq=16'hFFFF at the kp=0 edge -> pc=16'h0000 after EXEC. With SINGLE_STEP_EN: start held high -> exactly one instruction, then cs rests in IDLE.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Handshake/bus bundle between the cpu_sequencer and its surroundings.
// The sequencer sees the master modport. The RAM operand reader, the
// decoder, the RAM and any test harness use the slave modport.
//   Into the sequencer:
//     start   leave IDLE (level)
//     halt    stop after the current instruction (read in EXEC)
//     mem_rd  instruction needs an execute-time memory read
//     kp      reader keep-reading flag
//     adq     next unread byte address from the reader
//     opnd    operand assembled by the reader
//     d       RAM read data
//   Out of the sequencer:
//     cs      control state
//     ir      instruction register
//     addr    address presented to the reader
//     pc      program counter
//     retired completed-instruction count
interface cpu_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             halt;
  logic             mem_rd;
  logic             kp;
  logic [15:0]      adq;
  logic [63:0]      opnd;
  logic [7:0]       d;
  logic [3:0]       cs;
  logic [7:0]       ir;
  logic [15:0]      addr;
  logic [15:0]      pc;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, halt, mem_rd, kp, adq, opnd, d,
    output cs, ir, addr, pc, retired
  );

  modport slave (
    output start, halt, mem_rd, kp, adq, opnd, d,
    input  cs, ir, addr, pc, retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: control-state sequencer for the mcpu core. It owns the
// program counter and the instruction register. It walks the RAM operand
// reader through its phases using the 4-bit control state cs.
// Ports:
//   clk  system clock; all state changes on posedge
//   rst  asynchronous, active-high reset
//   bus  cpu_sequencer_if.master: start/halt/mem_rd/kp/adq/opnd/d in,
//        cs/ir/addr/pc/retired out
// Optional build macro SINGLE_STEP_EN:
//   When it is defined, each instruction returns to IDLE instead of
//   fetching the next one. start must be seen low in IDLE before it
//   launches another instruction, so a start that is held high runs
//   exactly one instruction.
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned CNT_W    = 16
) (
  input logic             clk,
  input logic             rst,
  cpu_sequencer_if.master bus
);

  // The encodings match the shared state header that the reader decodes.
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    OPCFT = 4'd1,
    OPLFT = 4'd2,
    OPLRD = 4'd3,
    ADRD  = 4'd4,
    EXERD = 4'd5,
    EXEC  = 4'd6,
    HALT  = 4'd7
  } state_t;

  state_t           state_r;
  logic [7:0]       ir_r;
  logic [15:0]      pc_r;
  logic [15:0]      npc_r;
  logic [CNT_W-1:0] retired_r;
  logic [15:0]      addr_s;
  logic             opnd_unused_s;
`ifdef SINGLE_STEP_EN
  // This flag is set once start has been seen low while in IDLE.
  logic             armed_r;
`endif

  // Only the low 16 bits of the operand are used, as the reload address.
  assign opnd_unused_s = ^bus.opnd[63:16];

  assign bus.cs      = state_r;
  assign bus.ir      = ir_r;
  assign bus.pc      = pc_r;
  assign bus.retired = retired_r;
  assign bus.addr    = addr_s;

  // Select the address that the reader loads in each state.
  always_comb begin
    addr_s = 16'h0000;
    case (state_r)
      IDLE, OPCFT: addr_s = pc_r;
      ADRD:        addr_s = bus.opnd[15:0];
      default:     addr_s = 16'h0000;
    endcase
  end

  // Sequencer state machine together with the pc, ir, npc and retired registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      pc_r      <= RESET_PC;
      npc_r     <= RESET_PC;
      ir_r      <= 8'h00;
      retired_r <= '0;
`ifdef SINGLE_STEP_EN
      armed_r   <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
`ifdef SINGLE_STEP_EN
          if (!bus.start) begin
            armed_r <= 1'b1;
          end else if (armed_r) begin
            armed_r <= 1'b0;
            state_r <= OPCFT;
          end else begin
            state_r <= IDLE;
          end
`else
          if (bus.start) begin
            state_r <= OPCFT;
          end else begin
            state_r <= IDLE;
          end
`endif
        end
        OPCFT: begin
          ir_r    <= bus.d;
          state_r <= OPLFT;
        end
        OPLFT: state_r <= OPLRD;
        OPLRD: begin
          // The reader consumes a byte on the kp=0 edge too, so the next pc is adq+1.
          if (!bus.kp) begin
            npc_r   <= bus.adq + 16'h0001;
            state_r <= bus.mem_rd ? ADRD : EXEC;
          end else begin
            state_r <= OPLRD;
          end
        end
        ADRD: state_r <= EXERD;
        EXERD: begin
          if (!bus.kp) begin
            state_r <= EXEC;
          end else begin
            state_r <= EXERD;
          end
        end
        EXEC: begin
          pc_r      <= npc_r;
          retired_r <= retired_r + CNT_W'(1);
          if (bus.halt) begin
            state_r <= HALT;
          end else begin
`ifdef SINGLE_STEP_EN
            state_r <= IDLE;
`else
            state_r <= OPCFT;
`endif
          end
        end
        HALT: state_r <= HALT;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
